// File: rtl/semiauto_nav_q.sv
// ---- semiauto_nav_q : semi-auto navigation controller with a command queue -- rev 1.0 ----
`default_nettype none

module semiauto_nav_q #(
  parameter int                DET_W       = 4,
  parameter logic [DET_W-1:0]  CROSS_MASK  = 4'b0111,
  parameter logic [DET_W-1:0]  CROSS_INV   = 4'b0110,
  parameter int                DEB_CYC     = 4,
  parameter int                TICK_DIV    = 2_000_000,
  parameter int                TURN_TICKS  = 100,
  parameter int                UTURN_TICKS = 200,
  parameter int                COOL_TICKS  = 50,
  parameter int                CMD_DEPTH   = 4
) (
  input  logic                       sys_clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic [DET_W-1:0]           detector,
  input  logic                       cmd_valid,
  input  logic [1:0]                 cmd,
  output logic                       cmd_ready,
  input  logic                       flush,
  output logic [1:0]                 state,
  output logic [3:0]                 moving_state,
  output logic                       crossroad,
  output logic [$clog2(CMD_DEPTH):0] cmd_count
);

  localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAXT = (UTURN_TICKS > TURN_TICKS)
                        ? ((UTURN_TICKS > COOL_TICKS) ? UTURN_TICKS : COOL_TICKS)
                        : ((TURN_TICKS > COOL_TICKS) ? TURN_TICKS : COOL_TICKS);
  localparam int CW   = $clog2(MAXT + 1);
  localparam int DW   = $clog2(DEB_CYC + 1);
  localparam int AW   = $clog2(CMD_DEPTH);
  localparam int QW   = AW + 1;

  localparam logic [3:0] MV_STOP  = 4'b0000;
  localparam logic [3:0] MV_FWD   = 4'b0001;
  localparam logic [3:0] MV_LEFT  = 4'b0100;
  localparam logic [3:0] MV_RIGHT = 4'b1000;

  typedef enum logic [1:0] {
    ST_FWD  = 2'b00,
    ST_WAIT = 2'b01,
    ST_TURN = 2'b10,
    ST_COOL = 2'b11
  } state_t;

  // Prescaler
  logic [PW-1:0] pre_q;
  logic          tick;

  assign tick = (pre_q == PW'(TICK_DIV - 1));

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) pre_q <= '0;
    else      pre_q <= tick ? '0 : pre_q + 1'b1;
  end

  // Crossroad debounce: deb_q counts consecutive raw-high edges, saturating at DEB_CYC
  logic          raw;
  logic [DW-1:0] deb_q, deb_d;
  logic          cross_q, cross_d;

  assign raw = |((detector ^ CROSS_INV) & CROSS_MASK);

  always_comb begin
    deb_d = '0;
    if (raw) deb_d = (deb_q == DW'(DEB_CYC)) ? deb_q : deb_q + 1'b1;
    cross_d = raw && (deb_d == DW'(DEB_CYC));
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      deb_q   <= '0;
      cross_q <= 1'b0;
    end else begin
      deb_q   <= deb_d;
      cross_q <= cross_d;
    end
  end

  // Command FIFO; ready only reflects the count, so a push offered while full is dropped
  logic [1:0]    mem_q [CMD_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [QW-1:0] fcnt_q, fcnt_d;
  logic          ready_q;
  logic          push, pop;
  logic [1:0]    head;

  assign push = cmd_valid & ready_q & ~flush;
  assign head = mem_q[rd_q];

  always_comb begin
    fcnt_d = fcnt_q;
    if (flush) fcnt_d = '0;
    else if (push && !pop) fcnt_d = fcnt_q + 1'b1;
    else if (pop && !push) fcnt_d = fcnt_q - 1'b1;
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      wr_q    <= '0;
      rd_q    <= '0;
      fcnt_q  <= '0;
      ready_q <= 1'b1;
    end else begin
      fcnt_q  <= fcnt_d;
      ready_q <= (fcnt_d != QW'(CMD_DEPTH));
      if (flush) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (push) wr_q <= wr_q + 1'b1;
        if (pop)  rd_q <= rd_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (push) mem_q[wr_q] <= cmd;
  end

  // Navigation FSM
  state_t        state_q, state_d;
  logic [3:0]    mov_q, mov_d;
  logic [CW-1:0] ph_q, ph_d;
  logic          uturn_q, uturn_d;
  logic [CW-1:0] turn_last, cool_last;

  assign turn_last = uturn_q ? CW'(UTURN_TICKS - 1) : CW'(TURN_TICKS - 1);
  assign cool_last = CW'(COOL_TICKS - 1);

  always_comb begin
    state_d = state_q;
    mov_d   = mov_q;
    uturn_d = uturn_q;
    pop     = 1'b0;
    if (!enable) begin
      state_d = ST_WAIT;
      mov_d   = MV_STOP;
      uturn_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_FWD: begin
          mov_d = MV_FWD;
          if (cross_q) begin
            state_d = ST_WAIT;
            mov_d   = MV_STOP;
          end
        end
        ST_WAIT: begin
          mov_d = MV_STOP;
          if ((fcnt_q != '0) && !flush) begin
            pop = 1'b1;
            unique case (head)
              2'b00: begin state_d = ST_COOL; mov_d = MV_FWD;   uturn_d = 1'b0; end
              2'b01: begin state_d = ST_TURN; mov_d = MV_LEFT;  uturn_d = 1'b0; end
              2'b10: begin state_d = ST_TURN; mov_d = MV_RIGHT; uturn_d = 1'b0; end
              2'b11: begin state_d = ST_TURN; mov_d = MV_RIGHT; uturn_d = 1'b1; end
            endcase
          end
        end
        ST_TURN: begin
          if (tick && (ph_q == turn_last)) begin
            state_d = ST_COOL;
            mov_d   = MV_FWD;
            uturn_d = 1'b0;
          end
        end
        ST_COOL: begin
          mov_d = MV_FWD;
          if (tick && (ph_q == cool_last)) state_d = ST_FWD;
        end
      endcase
    end

    ph_d = ph_q;
    if (!enable || (state_d != state_q)) ph_d = '0;
    else if (tick)                        ph_d = ph_q + 1'b1;
  end

  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_WAIT;
      mov_q   <= MV_STOP;
      ph_q    <= '0;
      uturn_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mov_q   <= mov_d;
      ph_q    <= ph_d;
      uturn_q <= uturn_d;
    end
  end

  assign state        = state_q;
  assign moving_state = mov_q;
  assign crossroad    = cross_q;
  assign cmd_count    = fcnt_q;
  assign cmd_ready    = ready_q;

endmodule

`default_nettype wire

// File: tb/tb_semiauto_nav_q.sv
// ---- tb_semiauto_nav_q : randomized bench for semiauto_nav_q against a queue-based model -- rev 1.0 ----
`default_nettype none

module tb_semiauto_nav_q;

  localparam int         TD   = 4;
  localparam int         TT   = 3;
  localparam int         UT   = 6;
  localparam int         CT   = 2;
  localparam int         DB   = 2;
  localparam int         DP   = 4;
  localparam logic [3:0] MASK = 4'b0111;
  localparam logic [3:0] INV  = 4'b0110;
  localparam logic [3:0] IDLE = 4'b0110;
  localparam logic [3:0] XRD  = 4'b0111;

  logic       sys_clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic [3:0] detector = IDLE;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd = 2'b00;
  logic       flush = 1'b0;
  logic       cmd_ready;
  logic [1:0] state;
  logic [3:0] moving_state;
  logic       crossroad;
  logic [2:0] cmd_count;

  semiauto_nav_q #(
    .DET_W(4), .CROSS_MASK(MASK), .CROSS_INV(INV), .DEB_CYC(DB), .TICK_DIV(TD),
    .TURN_TICKS(TT), .UTURN_TICKS(UT), .COOL_TICKS(CT), .CMD_DEPTH(DP)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .enable(enable), .detector(detector),
    .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready), .flush(flush),
    .state(state), .moving_state(moving_state), .crossroad(crossroad), .cmd_count(cmd_count)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Model: 0 FWD, 1 WAIT, 2 TURN, 3 COOL; timed states count remaining ticks down
  int m_st, m_mov, m_cross, m_run, m_rem, m_k;
  int q[$];

  task automatic model_reset();
    m_st = 1; m_mov = 0; m_cross = 0; m_run = 0; m_rem = 0; m_k = 0;
    q.delete();
  endtask

  task automatic model_step();
    bit tick, rdy, raw;
    int h;
    if (!rst) begin
      model_reset();
      return;
    end
    tick = ((m_k % TD) == TD - 1);
    m_k++;
    rdy = (q.size() < DP);
    if (!enable) begin
      m_st = 1; m_mov = 0;
    end else begin
      case (m_st)
        0: if (m_cross != 0) begin m_st = 1; m_mov = 0; end else m_mov = 1;
        1: begin
          m_mov = 0;
          if (q.size() > 0 && !flush) begin
            h = q.pop_front();
            case (h)
              0: begin m_st = 3; m_mov = 1; m_rem = CT; end
              1: begin m_st = 2; m_mov = 4; m_rem = TT; end
              2: begin m_st = 2; m_mov = 8; m_rem = TT; end
              default: begin m_st = 2; m_mov = 8; m_rem = UT; end
            endcase
          end
        end
        2: if (tick) begin
          m_rem--;
          if (m_rem == 0) begin m_st = 3; m_mov = 1; m_rem = CT; end
        end
        default: begin
          m_mov = 1;
          if (tick) begin
            m_rem--;
            if (m_rem == 0) m_st = 0;
          end
        end
      endcase
    end
    if (flush) q.delete();
    else if (cmd_valid && rdy) q.push_back(int'(cmd));
    raw = (((detector ^ INV) & MASK) != 4'b0000);
    if (raw) begin
      if (m_run < 1000) m_run++;
    end else m_run = 0;
    m_cross = (m_run >= DB) ? 1 : 0;
  endtask

  task automatic compare_all();
    check("state", state, m_st);
    check("moving", moving_state, m_mov);
    check("crossroad", crossroad, m_cross);
    check("cmd_count", cmd_count, q.size());
    check("cmd_ready", cmd_ready, (q.size() < DP) ? 1 : 0);
  endtask

  task automatic cycle();
    @(posedge sys_clk);
    model_step();
    @(negedge sys_clk);
    compare_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic push(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd = c;
    cycle();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_turn();
    for (int i = 0; i < 40 && m_st != 2; i++) cycle();
    check("reach_turn", state, 2);
  endtask

  initial begin
    model_reset();
    run(3);
    check("rst_state", state, 1);
    check("rst_count", cmd_count, 0);
    rst = 1'b1;

    // Queue a left turn while disabled, then enable: TURN/LEFT, COOL, FWD
    push(2'b01);
    enable = 1'b1;
    run(40);
    check("fwd_after_turn", state, 0);

    // Glitch does not stop; a held crossroad does
    detector = XRD; cycle();
    detector = IDLE; run(2);
    check("glitch_no_stop", state, 0);
    detector = XRD; run(2);
    check("xrd_debounced", crossroad, 1);
    cycle();
    check("xrd_stop", state, 1);
    detector = IDLE;

    // U-turn then fwd
    push(2'b11);
    push(2'b00);
    run(45);
    detector = XRD; run(3);
    detector = IDLE; run(20);

    // FIFO limits
    enable = 1'b0;
    push(2'b01); push(2'b10); push(2'b11); push(2'b00); push(2'b01);
    check("full_count", cmd_count, 4);
    check("full_ready", cmd_ready, 0);
    enable = 1'b1; cmd_valid = 1'b1; cmd = 2'b10;
    cycle();
    enable = 1'b0; flush = 1'b1;
    cycle();
    cmd_valid = 1'b0; flush = 1'b0;
    check("flush_count", cmd_count, 0);

    // Enable drop mid-TURN keeps the queue
    push(2'b10); push(2'b00);
    enable = 1'b1;
    wait_turn();
    run(3);
    enable = 1'b0; run(2);
    check("dis_state", state, 1);
    check("dis_fifo", cmd_count, 1);
    enable = 1'b1; run(20);

    // Asynchronous reset mid-TURN
    enable = 1'b0; cycle();
    push(2'b01);
    enable = 1'b1;
    wait_turn();
    run(2);
    rst = 1'b0;
    #1;
    check("arst_state", state, 1);
    check("arst_moving", moving_state, 0);
    check("arst_count", cmd_count, 0);
    model_reset();
    run(2);
    rst = 1'b1;
    run(6);
    check("idle_wait", state, 1);

    // Randomized traffic
    for (int i = 0; i < 900; i++) begin
      enable    = ($urandom_range(0, 99) < 95);
      cmd_valid = ($urandom_range(0, 99) < 25);
      cmd       = 2'($urandom_range(0, 3));
      flush     = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 12) detector = 4'($urandom_range(0, 15));
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
